// File: rtl/riscv_cpu_pkg.sv
// Shared CPU constants and types.
//   DATA_WIDTH           : core data path width (32).
//   MEM_RESP_MAX_LATENCY : deepest response pipeline data_mem_responder supports.
//   mem_gnt_state_e      : states of the data-memory grant-stall FSM.
package riscv_cpu_pkg;

  localparam int DATA_WIDTH           = 32;
  localparam int MEM_RESP_MAX_LATENCY = 4;

  typedef enum logic {
    GNT_IDLE,
    GNT_WAIT
  } mem_gnt_state_e;

endpackage

// File: rtl/data_mem_resp_pipe.sv
// Fixed-latency response shift register for data_mem_responder.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset.
//   in_valid     : a transaction is accepted on this edge.
//   in_data      : its response word (read data or 0 for writes).
//   out_valid    : response valid, READ_LATENCY cycles after acceptance.
//   out_data     : response word; holds the last response between responses.
module data_mem_resp_pipe
  import riscv_cpu_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [READ_LATENCY-1:0] vld_p;
  logic [DATA_WIDTH-1:0]   dat_p [READ_LATENCY];

  // Stage 1 only loads on acceptance, so the last response value ripples
  // through the later stages and the output holds it between responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p <= '0;
      for (int i = 0; i < READ_LATENCY; i++) dat_p[i] <= '0;
    end else begin
      vld_p[0] <= in_valid;
      if (in_valid) dat_p[0] <= in_data;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i] <= vld_p[i-1];
        dat_p[i] <= dat_p[i-1];
      end
    end
  end

  assign out_valid = vld_p[READ_LATENCY-1];
  assign out_data  = dat_p[READ_LATENCY-1];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory target for the load/store unit's req/gnt/rvalid interface.
// Word-wide RAM, optional grant stall, fixed-latency in-order responses.
// Ports:
//   clk_i, rst_i  : clock, asynchronous active-high reset.
//   data_req_i    : transaction request, held until granted.
//   data_gnt_o    : request accepted this cycle.
//   data_addr_i   : byte address (low two bits and bits above the RAM ignored).
//   data_we_i     : 1 = write, 0 = read.
//   data_wdata_i  : write data (full word).
//   data_rvalid_o : one-cycle response strobe per transaction.
//   data_rdata_o  : read data, 0 for write responses.
module data_mem_responder
  import riscv_cpu_pkg::*;
#(
  parameter int NUM_WORDS    = 1024,
  parameter int READ_LATENCY = 1,
  parameter int GNT_DELAY    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  data_req_i,
  output logic                  data_gnt_o,
  input  logic [DATA_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [DATA_WIDTH-1:0] data_wdata_i,
  output logic                  data_rvalid_o,
  output logic [DATA_WIDTH-1:0] data_rdata_o
);

  localparam int IDX_W = $clog2(NUM_WORDS);

  logic [IDX_W-1:0]      idx;
  logic                  accept;
  logic [DATA_WIDTH-1:0] resp_data;
  logic [DATA_WIDTH-1:0] ram [NUM_WORDS];
  logic                  unused_addr;

  assign idx         = data_addr_i[IDX_W+1:2];
  assign unused_addr = ^{data_addr_i[DATA_WIDTH-1:IDX_W+2], data_addr_i[1:0]};
  assign accept      = data_req_i && data_gnt_o;

  // RAM is deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (accept && data_we_i) ram[idx] <= data_wdata_i;
  end

  // Old contents are read on the accept edge; a write on the previous edge
  // is therefore already visible to a read accepted the next cycle.
  assign resp_data = data_we_i ? '0 : ram[idx];

  generate
    if (GNT_DELAY == 0) begin : g_comb_gnt
      assign data_gnt_o = data_req_i && !rst_i;
    end else begin : g_fsm_gnt
      localparam logic [2:0] GNT_CNT = 3'(GNT_DELAY);

      mem_gnt_state_e state_q, state_d;
      logic [2:0]     cnt_q, cnt_d;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          state_q <= GNT_IDLE;
          cnt_q   <= '0;
        end else begin
          state_q <= state_d;
          cnt_q   <= cnt_d;
        end
      end

      // Entering WAIT already counts the first held cycle, so gnt lands
      // exactly GNT_DELAY cycles after req rises.
      always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
          GNT_IDLE: begin
            cnt_d = '0;
            if (data_req_i) begin
              state_d = GNT_WAIT;
              cnt_d   = 3'd1;
            end
          end
          GNT_WAIT: begin
            if (!data_req_i || (cnt_q == GNT_CNT)) begin
              state_d = GNT_IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
          default: begin
            state_d = GNT_IDLE;
            cnt_d   = '0;
          end
        endcase
      end

      always_comb begin
        data_gnt_o = (state_q == GNT_WAIT) && (cnt_q == GNT_CNT) &&
                     data_req_i && !rst_i;
      end
    end
  endgenerate

  data_mem_resp_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .in_valid  (accept),
    .in_data   (resp_data),
    .out_valid (data_rvalid_o),
    .out_data  (data_rdata_o)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder across three configurations.
module tb_data_mem_responder;
  import riscv_cpu_pkg::*;

  localparam int N = 3;

  function automatic int gd_of(int k);
    case (k)
      2:       return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int rl_of(int k);
    case (k)
      1:       return 4;
      2:       return 2;
      default: return 1;
    endcase
  endfunction

  function automatic int nw_of(int k);
    case (k)
      1:       return 16;
      default: return 1024;
    endcase
  endfunction

  logic        clk = 1'b0;
  int          cyc = 0;
  logic        rst    [N];
  logic        req    [N];
  logic        gnt    [N];
  logic        we     [N];
  logic        rvalid [N];
  logic [31:0] addr   [N];
  logic [31:0] wdata  [N];
  logic [31:0] rdata  [N];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  generate
    for (genvar g = 0; g < N; g++) begin : g_dut
      data_mem_responder #(
        .NUM_WORDS    (nw_of(g)),
        .READ_LATENCY (rl_of(g)),
        .GNT_DELAY    (gd_of(g))
      ) u_dut (
        .clk_i         (clk),
        .rst_i         (rst[g]),
        .data_req_i    (req[g]),
        .data_gnt_o    (gnt[g]),
        .data_addr_i   (addr[g]),
        .data_we_i     (we[g]),
        .data_wdata_i  (wdata[g]),
        .data_rvalid_o (rvalid[g]),
        .data_rdata_o  (rdata[g])
      );
    end
  endgenerate

  typedef struct {
    int          k;
    int          due;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] model [N][1024];
  logic [31:0] last  [N];
  int          compared   = 0;
  int          mismatched = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever a DUT presents a response.
  always @(negedge clk) begin
    exp_t e;
    for (int k = 0; k < N; k++) begin
      if (rst[k] === 1'b1) begin
        last[k] = 32'h0;
        check("reset_rvalid", 32'(rvalid[k]), 32'h0);
        check("reset_rdata", rdata[k], 32'h0);
      end else if (rvalid[k] === 1'b1) begin
        if (sb.size() > 0 && sb[0].k == k) begin
          e = sb.pop_front();
          check("rvalid_cycle", cyc, e.due);
          check("rdata", rdata[k], e.data);
          last[k] = e.data;
        end else begin
          check("unexpected_rvalid", 32'h1, 32'h0);
          last[k] = rdata[k];
        end
      end else begin
        check("rdata_hold", rdata[k], last[k]);
      end
    end
    if (sb.size() > 0 && sb[0].due < cyc) begin
      check("missed_rvalid", 32'h0, 32'h1);
      void'(sb.pop_front());
    end
  end

  function automatic logic [31:0] mk_addr(int k, int idx);
    logic [31:0] r;
    logic [31:0] span;
    r    = $urandom;
    span = 32'(nw_of(k) * 4);
    return (r & ~(span - 32'd1)) | 32'(idx << 2) | (r & 32'd3);
  endfunction

  // Drives one transaction from posedge+1; returns at posedge+1 after acceptance.
  task automatic do_txn(int k, bit w, logic [31:0] a, logic [31:0] d);
    int start;
    int n;
    int idx;
    bit got;
    start = cyc;
    got   = 1'b0;
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      if (gnt[k] === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("gnt_timeout", 32'h0, 32'h1);
      req[k] = 1'b0;
      return;
    end
    n = cyc;
    check("gnt_cycle", n, start + gd_of(k));
    idx = int'(a >> 2) % nw_of(k);
    if (w) begin
      model[k][idx] = d;
      sb.push_back('{k, n + rl_of(k), 32'h0});
    end else begin
      sb.push_back('{k, n + rl_of(k), model[k][idx]});
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 20 && sb.size() > 0; t++) @(posedge clk);
    @(posedge clk); #1;
    if (sb.size() > 0) begin
      check("drain_timeout", sb.size(), 32'h0);
      sb.delete();
    end
  endtask

  task automatic rand_phase(int k, int count);
    int widx [$];
    int idx;
    for (int i = 0; i < count; i++) begin
      if (widx.size() == 0 || $urandom_range(0, 2) == 0) begin
        idx = $urandom_range(0, nw_of(k) - 1);
        widx.push_back(idx);
        do_txn(k, 1'b1, mk_addr(k, idx), $urandom);
      end else begin
        idx = widx[$urandom_range(0, widx.size() - 1)];
        do_txn(k, 1'b0, mk_addr(k, idx), 32'h0);
      end
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end
  endtask

  initial begin
    for (int k = 0; k < N; k++) begin
      rst[k] = 1'b1; req[k] = 1'b1; we[k] = 1'b0;
      addr[k] = 32'h0; wdata[k] = 32'h0; last[k] = 32'h0;
    end

    // Reset with req held high: no grant, no response.
    repeat (3) begin
      @(negedge clk);
      for (int k = 0; k < N; k++) check("reset_gnt", 32'(gnt[k]), 32'h0);
    end
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      req[k] = 1'b0; rst[k] = 1'b0;
    end
    @(posedge clk); #1;

    // Instance 0: no stall, latency 1.
    do_txn(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
    do_txn(0, 1'b0, 32'h0000_0040, 32'h0);
    do_txn(0, 1'b1, 32'h1000_0004, 32'h1234_5678);
    do_txn(0, 1'b0, 32'h0000_0007, 32'h0);
    drain();
    rand_phase(0, 120);
    drain();

    // Instance 1: no stall, latency 4, 16 words.
    for (int i = 0; i < 8; i++) do_txn(1, 1'b1, 32'(i * 4), $urandom);
    drain();
    for (int i = 0; i < 8; i++) do_txn(1, 1'b0, 32'(i * 4), 32'h0);
    drain();
    for (int i = 0; i < 3; i++) do_txn(1, 1'b0, 32'(i * 4), 32'h0);
    rst[1] = 1'b1;
    sb.delete();
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    do_txn(1, 1'b0, mk_addr(1, 3), 32'h0);
    drain();
    rand_phase(1, 120);
    drain();

    // Instance 2: grant stall 3, latency 2.
    do_txn(2, 1'b1, 32'h0000_0100, 32'hA5A5_0F0F);
    drain();
    do_txn(2, 1'b0, 32'h0000_0100, 32'h0);
    drain();
    req[2] = 1'b1; we[2] = 1'b0; addr[2] = 32'h0000_0100;
    @(negedge clk);
    check("gnt_early", 32'(gnt[2]), 32'h0);
    @(posedge clk); #1;
    req[2] = 1'b0;
    @(negedge clk);
    check("gnt_dropped", 32'(gnt[2]), 32'h0);
    @(posedge clk); #1;
    do_txn(2, 1'b0, 32'h0000_0100, 32'h0);
    drain();
    rand_phase(2, 60);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory req/gnt/rvalid interface: the target that the load/store unit drives. It accepts one transaction per cycle and performs word writes into an internal RAM. Every accepted transaction gets an in-order response after a fixed latency. It serves as the simulation and FPGA data memory behind the CPU, with parameterisable grant stall and read latency for exercising the initiator.

## Interface
Parameters:
- NUM_WORDS, 1024: RAM depth in 32-bit words; power of two, at least 2.
- READ_LATENCY, 1: cycles from acceptance edge to rvalid; legal range 1..4.
- GNT_DELAY, 0: cycles req must be held before gnt; legal range 0..7, where 0 gives combinational grant.

Ports (clock and reset first):
- clk_i, in, 1: single clock, rising edge.
- rst_i, in, 1: reset, asynchronous and active-high.
- data_req_i, in, 1: transaction request.
- data_gnt_o, out, 1: request accepted this cycle.
- data_addr_i, in, DATA_WIDTH: byte address.
- data_we_i, in, 1: 1 for write, 0 for read.
- data_wdata_i, in, DATA_WIDTH: write data.
- data_rvalid_o, out, 1: response valid, one cycle per transaction.
- data_rdata_o, out, DATA_WIDTH: read data; 0 for write responses.

## Operation
- Acceptance is the cycle with data_req_i && data_gnt_o. The initiator holds req, addr, we and wdata stable from req rise until acceptance.
- Word index is data_addr_i[$clog2(NUM_WORDS)+1:2].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses alias modulo NUM_WORDS*4.
- Write: on the acceptance edge, RAM[index] <= data_wdata_i; all 32 bits are written.
- Read: the word is sampled on the acceptance edge, so a read accepted the cycle after a write to the same index returns the new data.
- Grant FSM when GNT_DELAY > 0:
  - IDLE: counter = 0, gnt = 0. On req, go to WAIT.
  - WAIT: counter increments each cycle while req is held. gnt = 1 when counter == GNT_DELAY.
  - On acceptance, return to IDLE with counter = 0.
  - req dropping before gnt returns to IDLE with the counter cleared; this is a protocol violation that the block tolerates.
  - Back-to-back requests therefore see GNT_DELAY stall cycles each.
- GNT_DELAY = 0: data_gnt_o = data_req_i && !rst_i. No FSM state; full throughput of one transaction per cycle.
- Response pipeline:
  - READ_LATENCY stages, each holding valid and data; shifts every cycle.
  - There is no backpressure, so the initiator must always accept rvalid.
  - Responses are strictly in acceptance order. Write responses carry rdata = 0.

## Timing
- Reset values:
  - data_gnt_o = 0; it is forced low while rst_i is high, even when GNT_DELAY = 0.
  - data_rvalid_o = 0, data_rdata_o = 0, all pipeline valids cleared, FSM in IDLE with counter 0.
- RAM contents are not reset.
- Acceptance in cycle N gives data_rvalid_o = 1 in cycle N+READ_LATENCY, for exactly one cycle.
- data_rdata_o holds the last response value between responses; it is not cleared.
- Maximum throughput is one acceptance per cycle when GNT_DELAY = 0, and one per GNT_DELAY+1 cycles otherwise.
- Outstanding responses never exceed READ_LATENCY; no storage beyond the pipeline is needed.
- Reset asserted mid-operation:
  - In-flight responses are dropped with no rvalid.
  - A partially counted grant is abandoned.
  - A write accepted on the same edge reset rises is not guaranteed.
- After reset deassertion, the first gnt is possible in the same cycle if GNT_DELAY = 0, otherwise after GNT_DELAY cycles of req.

## Structure
- riscv_cpu_pkg holds DATA_WIDTH, which already exists, and a new MEM_RESP_MAX_LATENCY = 4 constant.
- The grant FSM state enum lives in the package as mem_gnt_state_e = {GNT_IDLE, GNT_WAIT}.
- Sub-module data_mem_resp_pipe, parameterised by READ_LATENCY: a shift register of {valid, data}.
- The RAM is an inferred array in the top module with a registered read into pipeline stage 1.

## Test plan
- Reset and idle: hold rst_i = 1 for 3 cycles with req = 1 -> gnt = 0, rvalid = 0, rdata = 0 throughout.
- Write then read (GNT_DELAY = 0, READ_LATENCY = 1):
  - Write 0xDEADBEEF to 0x40, then read 0x40 the next cycle.
  - Required: write rvalid at N+1 with rdata = 0; read rvalid at N+2 with rdata = 0xDEADBEEF.
- Aliasing and low bits (NUM_WORDS = 1024): write 0x12345678 to 0x1000_0004, read 0x0000_0007 -> 0x12345678.
- Grant stall (GNT_DELAY = 3, READ_LATENCY = 2):
  - req rises in cycle 0 -> gnt = 1 only in cycle 3, rvalid in cycle 5.
  - Dropping req in cycle 1 and re-raising it in cycle 2 -> gnt in cycle 5.
- Pipelined burst (GNT_DELAY = 0, READ_LATENCY = 4):
  - 8 consecutive reads of preloaded words 0..7 -> rvalid high for cycles 4..11, with data in order.
- Reset mid-burst: assert rst_i while 3 responses are in flight -> no rvalid after reset. The next read returns correct data at its nominal latency.
